// File: rtl/rx_sync_ctrl.sv
// Receive-side word-sync controller for the 8b/10b path: acquires lock on repeated
// K28.5 commas, drops it on accumulated decoder errors, and drives aligner bit-slips.
module rx_sync_ctrl #(
  parameter int COMMA_NEED   = 3,
  parameter int ERR_LIMIT    = 4,
  parameter int GOOD_RECOVER = 4,
  parameter int SLIP_TIMEOUT = 16,
  parameter int SLIP_SETTLE  = 2
) (
  input  logic       BitCLK_10,
  input  logic       Reset,
  input  logic       RxValid,
  input  logic [9:0] RxParallel_10,
  input  logic       CodeErr,
  output logic       SyncAcquired,
  output logic       DecodeEn,
  output logic       BitSlip,
  output logic [1:0] SyncState,
  output logic [7:0] SyncLossCount
);

  typedef enum logic [1:0] {
    ST_LOSS = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2,
    ST_SLIP = 2'd3
  } state_t;

  localparam logic [9:0] COMMA_RDN = 10'b0011111010;
  localparam logic [9:0] COMMA_RDP = 10'b1100000101;
  localparam logic [2:0] COMMA_N   = 3'(COMMA_NEED);
  localparam logic [2:0] ERR_N     = 3'(ERR_LIMIT);
  localparam logic [3:0] GOOD_N    = 4'(GOOD_RECOVER);
  localparam logic [7:0] SLIP_TO   = 8'(SLIP_TIMEOUT);
  localparam logic [3:0] SETTLE_N  = 4'(SLIP_SETTLE);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] comma_cnt_q, comma_cnt_d;
  logic [2:0] err_cnt_q, err_cnt_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [7:0] slip_cnt_q, slip_cnt_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [7:0] loss_cnt_q, loss_cnt_d;
  logic       sync_acq_q, sync_acq_d;
  logic       decode_en_q, decode_en_d;
  logic       bit_slip_q, bit_slip_d;
  logic       is_comma;

  assign is_comma = (RxParallel_10 == COMMA_RDN) || (RxParallel_10 == COMMA_RDP);

  always_comb begin
    state_d      = state_q;
    comma_cnt_d  = comma_cnt_q;
    err_cnt_d    = err_cnt_q;
    good_cnt_d   = good_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    settle_cnt_d = settle_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    bit_slip_d   = 1'b0;
    // Qualifier follows the state the word was sampled in, not the one it leads to.
    decode_en_d  = RxValid && (state_q == ST_SYNC);

    if (RxValid) begin
      case (state_q)
        ST_LOSS: begin
          if (is_comma && !CodeErr) begin
            if (COMMA_NEED == 1) begin
              state_d    = ST_SYNC;
              err_cnt_d  = 3'd0;
              good_cnt_d = 4'd0;
            end else begin
              state_d     = ST_ACQ;
              comma_cnt_d = 3'd1;
            end
          end else if (slip_cnt_q + 8'd1 == SLIP_TO) begin
            state_d      = ST_SLIP;
            bit_slip_d   = 1'b1;
            settle_cnt_d = 4'd0;
            slip_cnt_d   = 8'd0;
          end else begin
            slip_cnt_d = slip_cnt_q + 8'd1;
          end
        end
        ST_ACQ: begin
          if (CodeErr) begin
            state_d    = ST_LOSS;
            slip_cnt_d = 8'd0;
          end else if (is_comma) begin
            if (comma_cnt_q + 3'd1 == COMMA_N) begin
              state_d    = ST_SYNC;
              err_cnt_d  = 3'd0;
              good_cnt_d = 4'd0;
            end else begin
              comma_cnt_d = comma_cnt_q + 3'd1;
            end
          end
        end
        ST_SYNC: begin
          if (CodeErr) begin
            good_cnt_d = 4'd0;
            if (err_cnt_q + 3'd1 == ERR_N) begin
              state_d    = ST_LOSS;
              slip_cnt_d = 8'd0;
              loss_cnt_d = sat_inc8(loss_cnt_q);
            end else begin
              err_cnt_d = err_cnt_q + 3'd1;
            end
          end else if (good_cnt_q + 4'd1 == GOOD_N) begin
            good_cnt_d = 4'd0;
            if (err_cnt_q != 3'd0) err_cnt_d = err_cnt_q - 3'd1;
          end else begin
            good_cnt_d = good_cnt_q + 4'd1;
          end
        end
        default: begin
          // Aligner output is unstable right after a slip, so content is ignored here.
          if (settle_cnt_q + 4'd1 == SETTLE_N) begin
            state_d    = ST_LOSS;
            slip_cnt_d = 8'd0;
          end else begin
            settle_cnt_d = settle_cnt_q + 4'd1;
          end
        end
      endcase
    end

    sync_acq_d = (state_d == ST_SYNC);
  end

  always_ff @(posedge BitCLK_10 or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_LOSS;
      comma_cnt_q  <= 3'd0;
      err_cnt_q    <= 3'd0;
      good_cnt_q   <= 4'd0;
      slip_cnt_q   <= 8'd0;
      settle_cnt_q <= 4'd0;
      loss_cnt_q   <= 8'd0;
      sync_acq_q   <= 1'b0;
      decode_en_q  <= 1'b0;
      bit_slip_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      comma_cnt_q  <= comma_cnt_d;
      err_cnt_q    <= err_cnt_d;
      good_cnt_q   <= good_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      sync_acq_q   <= sync_acq_d;
      decode_en_q  <= decode_en_d;
      bit_slip_q   <= bit_slip_d;
    end
  end

  assign SyncState     = state_q;
  assign SyncAcquired  = sync_acq_q;
  assign DecodeEn      = decode_en_q;
  assign BitSlip       = bit_slip_q;
  assign SyncLossCount = loss_cnt_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Directed bench for rx_sync_ctrl: sync acquisition, ACQ abort, slip timing,
// error tolerance in SYNC, idle gaps and asynchronous reset.
module tb_rx_sync_ctrl;

  localparam logic [9:0] K_RDN = 10'b0011111010;
  localparam logic [9:0] K_RDP = 10'b1100000101;
  localparam logic [9:0] DW    = 10'b0101010101;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [9:0] rx_data;
  logic       code_err;
  logic       sync_acq;
  logic       decode_en;
  logic       bit_slip;
  logic [1:0] sync_state;
  logic [7:0] loss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  rx_sync_ctrl dut (
    .BitCLK_10    (clk),
    .Reset        (rst),
    .RxValid      (rx_valid),
    .RxParallel_10(rx_data),
    .CodeErr      (code_err),
    .SyncAcquired (sync_acq),
    .DecodeEn     (decode_en),
    .BitSlip      (bit_slip),
    .SyncState    (sync_state),
    .SyncLossCount(loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one word and sample just after the clock edge that consumes it.
  task automatic step(input logic v, input logic [9:0] d, input logic e);
    rx_valid = v;
    rx_data  = d;
    code_err = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, sync_state, 0);
    check({tag, "_sync"}, sync_acq, 0);
    check({tag, "_dec"}, decode_en, 0);
    check({tag, "_slip"}, bit_slip, 0);
    check({tag, "_loss"}, loss_cnt, 0);
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    code_err = 1'b0;
    repeat (2) step(1'b0, '0, 1'b0);
    check_zero("reset");
    rst = 1'b0;

    // Acquire: 3 commas, 0->1->1->2
    step(1'b1, K_RDN, 1'b0);
    check("acq_c1", sync_state, 1);
    step(1'b1, K_RDN, 1'b0);
    check("acq_c2", sync_state, 1);
    check("acq_c2_sync", sync_acq, 0);
    step(1'b1, K_RDN, 1'b0);
    check("acq_c3", sync_state, 2);
    check("acq_c3_sync", sync_acq, 1);
    check("acq_c3_dec", decode_en, 0);
    step(1'b1, DW, 1'b0);
    check("sync_dec", decode_en, 1);

    // Idle gap in SYNC
    for (int i = 0; i < 10; i++) begin
      step(1'b0, DW, 1'b1);
      check("gap_state", sync_state, 2);
      check("gap_sync", sync_acq, 1);
      check("gap_dec", decode_en, 0);
    end

    // Errors spaced by 3 clean words -> loss on 4th error
    for (int i = 0; i < 3; i++) begin
      step(1'b1, DW, 1'b1);
      repeat (3) step(1'b1, DW, 1'b0);
    end
    check("err3_state", sync_state, 2);
    step(1'b1, DW, 1'b1);
    check("err4_state", sync_state, 0);
    check("err4_sync", sync_acq, 0);
    check("err4_dec", decode_en, 1);
    check("err4_loss", loss_cnt, 1);

    // Errored comma in LOSS is not a comma
    step(1'b1, K_RDN, 1'b1);
    check("errcomma", sync_state, 0);

    // Resync on RD+ commas, then errors spaced by 4 clean words are forgiven
    repeat (3) step(1'b1, K_RDP, 1'b0);
    check("resync", sync_state, 2);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, DW, 1'b1);
      repeat (4) step(1'b1, DW, 1'b0);
    end
    check("recover_state", sync_state, 2);
    check("recover_loss", loss_cnt, 1);

    // 4 consecutive errors -> loss
    repeat (4) step(1'b1, DW, 1'b1);
    check("burst_state", sync_state, 0);
    check("burst_loss", loss_cnt, 2);

    // ACQ abort on error, then 3 fresh commas needed
    repeat (2) step(1'b1, K_RDN, 1'b0);
    check("abort_pre", sync_state, 1);
    step(1'b1, DW, 1'b1);
    check("abort", sync_state, 0);
    repeat (2) step(1'b1, K_RDN, 1'b0);
    check("abort_c2", sync_state, 1);
    step(1'b1, K_RDN, 1'b0);
    check("abort_c3", sync_state, 2);
    repeat (4) step(1'b1, DW, 1'b1);
    check("loss3", loss_cnt, 3);

    // Slip after 16 valid non-comma words; RxValid=0 words do not count
    repeat (7) step(1'b1, DW, 1'b0);
    step(1'b0, DW, 1'b0);
    repeat (8) step(1'b1, DW, 1'b0);
    check("slip15_state", sync_state, 0);
    check("slip15_bs", bit_slip, 0);
    step(1'b1, DW, 1'b0);
    check("slip16_state", sync_state, 3);
    check("slip16_bs", bit_slip, 1);
    step(1'b0, DW, 1'b0);
    check("slip_hold_bs", bit_slip, 0);
    check("slip_hold_state", sync_state, 3);
    step(1'b1, K_RDN, 1'b0);
    check("settle1", sync_state, 3);
    check("settle1_bs", bit_slip, 0);
    step(1'b1, K_RDN, 1'b0);
    check("settle2", sync_state, 0);
    repeat (15) step(1'b1, DW, 1'b0);
    check("slip2_pre", bit_slip, 0);
    step(1'b1, DW, 1'b0);
    check("slip2_state", sync_state, 3);
    check("slip2_bs", bit_slip, 1);

    // Asynchronous reset while BitSlip is high
    rst = 1'b1;
    #1;
    check_zero("rst_slip");
    @(negedge clk);
    rst = 1'b0;

    // Five sync losses, then reset while in SYNC
    for (int k = 0; k < 5; k++) begin
      repeat (3) step(1'b1, K_RDN, 1'b0);
      repeat (4) step(1'b1, DW, 1'b1);
    end
    check("loss5_cnt", loss_cnt, 5);
    repeat (3) step(1'b1, K_RDN, 1'b0);
    step(1'b1, DW, 1'b0);
    check("loss5_state", sync_state, 2);
    check("loss5_dec", decode_en, 1);
    rst = 1'b1;
    #1;
    check_zero("rst_sync");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, DW, 1'b0);
    check_zero("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
